riscv_regfile_wb: RTL and testbench
===================================

Name: riscv_regfile_wb

Overview:
- 32-entry integer register file feeding the R-type execute stage and consuming its writeback.
- Provides `rv1`/`rv2` from `rs1`/`rs2` addresses.
- Accepts the R-type result (`regdata_R`) on a single write port.
- After reset, runs a clear sequencer that zeroes storage one entry per cycle, so the array can map to RAM without a reset network. `busy` stalls the core until clearing is done.

Parameters:
- XLEN, 32, data width of each register and of the read/write data ports.
- NREGS, 32, number of architectural registers; addresses are $clog2(NREGS) bits (5 at default).
- BYPASS, 1, when 1, a same-cycle write to a register being read is forwarded to the read port; when 0, the read returns the old contents.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- rs1_addr  input  5  read port 1 address (instr[19:15]).
- rs2_addr  input  5  read port 2 address (instr[24:20]).
- rv1  output  XLEN  read port 1 data, to execute stage `rv1`.
- rv2  output  XLEN  read port 2 data, to execute stage `rv2`.
- we  input  1  write request, qualified by `busy`.
- rd_addr  input  5  write address (instr[11:7]).
- wdata  input  XLEN  write data, from execute stage `regdata_R`.
- busy  output  1  high while the clear sequence runs; upstream must hold off issuing.

Behaviour:
- State machine with two states, CLEAR and READY, plus a clear index `clr_idx` (5 bits).
- Reset:
  - `rst`=1 at a rising edge sets state to CLEAR, `clr_idx` to 0 and `busy` to 1.
  - Reset values of outputs: `busy`=1, `rv1`=0, `rv2`=0.
  - Reset asserted mid-clear restarts the sequence from index 0.
  - Reset asserted in READY discards any concurrent write.
- CLEAR:
  - Each edge with `rst`=0 writes 0 to entry `clr_idx` and increments `clr_idx`.
  - The edge that writes index NREGS-1 moves the state to READY; `busy` falls after that edge.
  - Exactly NREGS non-reset edges elapse between `rst` deassertion and `busy`=0.
- Busy rules:
  - While `busy`=1, external writes are dropped with no error flag.
  - While `busy`=1, `rv1` and `rv2` are forced to 0.
- READY writes:
  - At a rising edge with `we`=1 and `rd_addr`!=0, the register is loaded with `wdata`.
  - Writes to x0 are ignored.
  - Write latency is one edge: the value is visible on a read starting the next cycle.
- Reads:
  - Combinational, zero-latency from address to data.
  - Address 0 always returns 0, regardless of `we`, `wdata` or BYPASS.
- Bypass (BYPASS=1):
  - If `we`=1, `rd_addr`!=0, `busy`=0 and `rs1_addr`==`rd_addr`, then `rv1`=`wdata` in the same cycle.
  - Same rule applies to `rv2`.
  - Both ports may bypass at once.
- Bypass (BYPASS=0): a read returns the pre-write contents during the write cycle.
- Simultaneous `rs1_addr`==`rs2_addr` is legal; both ports return the same value.
- No other side effects.
- Only address bits [4:0] are used; with NREGS=32 there is no out-of-range case.

Test Plan:
- Clear sequence:
  - Stimulus: assert `rst` for 2 edges, release, count edges until `busy`=0.
  - Required: exactly 32; `rv1`/`rv2`=0 throughout.
  - Then: read all 32 registers; each returns 0x00000000.
- Basic write/read:
  - Stimulus: write x5=0xDEADBEEF, next cycle `rs1_addr`=5, `rs2_addr`=5.
  - Required: `rv1`=`rv2`=0xDEADBEEF.
  - Then: write x5=0x1, read x5; required 0x00000001.
- x0 hardwiring:
  - Stimulus: `we`=1, `rd_addr`=0, `wdata`=0xFFFFFFFF; same cycle and next cycle read `rs1_addr`=0.
  - Required: `rv1`=0 in both cycles, including same-cycle with BYPASS=1.
- Bypass:
  - Setup: x7=0x11.
  - Stimulus: same cycle `we`=1, `rd_addr`=7, `wdata`=0x22, `rs1_addr`=7.
  - Required: `rv1`=0x22 with BYPASS=1; `rv1`=0x11 with BYPASS=0; next cycle 0x22 in both builds.
- Writes during busy:
  - Stimulus: during CLEAR at cycle 3, `we`=1, `rd_addr`=31, `wdata`=0xA5A5A5A5.
  - Required: after `busy` falls, x31 reads 0 (write dropped).
- Reset mid-operation:
  - Stimulus: write x10=0x1234; later assert `rst` at clear index 17, release.
  - Required: `busy` high for a further 32 edges; x10 reads 0 afterwards.
- Integration with execute stage:
  - Setup: x1=7, x2=5.
  - Stimulus: issue add rd=3, then sub rd=4 (rs1=x1, rs2=x2).
  - Required: x3=12, x4=2.

Source files
------------

// File: rtl/riscv_regfile_wb.sv
// rtl/riscv_regfile_wb.sv - 32-entry integer register file with post-reset clear sequencer
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   rs1_addr  read port 1 address      -> rv1 read port 1 data
//   rs2_addr  read port 2 address      -> rv2 read port 2 data
//   we        write request (ignored while busy)
//   rd_addr   write address
//   wdata     write data from the execute stage result
//   busy      high while the storage is being zeroed after reset
module riscv_regfile_wb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rv1,
    output logic [XLEN-1:0] rv2,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [0:0]      state;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] regs [NREGS];

    assign busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == LAST_IDX) begin
                state <= READY;
            end
        end
    end

    // The array has no reset so it can map onto RAM; the sequencer zeroes
    // it instead. A reset edge blocks every write, including a concurrent
    // external write while READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else if (we && (rd_addr != '0)) begin
                regs[rd_addr] <= wdata;
            end
        end
    end

    logic write_live;
    assign write_live = we && (rd_addr != '0) && !busy;

    always_comb begin
        rv1 = '0;
        if (!busy && (rs1_addr != '0)) begin
            if ((BYPASS != 0) && write_live && (rd_addr == rs1_addr)) begin
                rv1 = wdata;
            end else begin
                rv1 = regs[rs1_addr];
            end
        end
    end

    always_comb begin
        rv2 = '0;
        if (!busy && (rs2_addr != '0)) begin
            if ((BYPASS != 0) && write_live && (rd_addr == rs2_addr)) begin
                rv2 = wdata;
            end else begin
                rv2 = regs[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_riscv_regfile_wb.sv
// tb/tb_riscv_regfile_wb.sv - scoreboard bench for riscv_regfile_wb, bypass and non-bypass builds
module tb_riscv_regfile_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;

    logic [31:0] rv1_b, rv2_b, rv1_n, rv2_n;
    logic        busy_b, busy_n;

    always #5 clk = ~clk;

    riscv_regfile_wb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rv1(rv1_b), .rv2(rv2_b), .we(we), .rd_addr(rd_addr),
        .wdata(wdata), .busy(busy_b)
    );

    riscv_regfile_wb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rv1(rv1_n), .rv2(rv2_n), .we(we), .rd_addr(rd_addr),
        .wdata(wdata), .busy(busy_n)
    );

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    logic [31:0] model [32];
    bit          mbusy = 1'b1;
    int          mcnt = 0;
    logic [31:0] last_rv1, last_rv2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp, input logic w,
                                           input logic [4:0] rd, input logic [31:0] d);
        if (mbusy || a == 5'd0) return 32'h0;
        if (byp && w && rd != 5'd0 && rd == a) return d;
        return model[a];
    endfunction

    task automatic push(input string tag, input int src, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive inputs, queue expectations, compare at the
    // falling edge, then advance the reference model across the rising edge.
    task automatic cycle(input string tag, input logic r, input logic w, input logic [4:0] rd,
                         input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] obs;
        exp_t e;
        rst = r; we = w; rd_addr = rd; wdata = d; rs1_addr = a1; rs2_addr = a2;
        push({tag, ".rv1_byp"}, 0, exp_rd(a1, 1'b1, w, rd, d));
        push({tag, ".rv2_byp"}, 1, exp_rd(a2, 1'b1, w, rd, d));
        push({tag, ".rv1_nobyp"}, 2, exp_rd(a1, 1'b0, w, rd, d));
        push({tag, ".rv2_nobyp"}, 3, exp_rd(a2, 1'b0, w, rd, d));
        push({tag, ".busy"}, 4, {31'd0, mbusy});
        push({tag, ".busy_nobyp"}, 5, {31'd0, mbusy});
        @(negedge clk);
        last_rv1 = rv1_b;
        last_rv2 = rv2_b;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.src)
                0: obs = rv1_b;
                1: obs = rv2_b;
                2: obs = rv1_n;
                3: obs = rv2_n;
                4: obs = {31'd0, busy_b};
                default: obs = {31'd0, busy_n};
            endcase
            check(e.tag, obs, e.val);
        end
        @(posedge clk);
        if (r) begin
            mbusy = 1'b1;
            mcnt = 0;
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (mbusy) begin
            mcnt++;
            if (mcnt == 32) mbusy = 1'b0;
        end else if (w && rd != 5'd0) begin
            model[rd] = d;
        end
        #1;
    endtask

    task automatic wait_clear(input string tag, input bit poke_busy_write);
        int n = 0;
        while (busy_b && n < 100) begin
            if (poke_busy_write && n == 3)
                cycle(tag, 1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0);
            else
                cycle(tag, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
            n++;
        end
        check({tag, ".edges"}, n, 32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        // Two raw reset edges bring both instances out of their unknown state.
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset.busy", {31'd0, busy_b}, 32'd1);
        check("reset.rv1", rv1_b, 32'h0);
        check("reset.rv2", rv2_b, 32'h0);

        // Clear sequence, with a dropped write at clear cycle 3.
        wait_clear("clear", 1'b1);
        for (int i = 0; i < 32; i++)
            cycle("zero", 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        cycle("busy_write_dropped", 1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
        check("x31_after_busy", last_rv1, 32'h0);

        // Basic write/read.
        cycle("wr_x5", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        cycle("rd_x5", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check("x5_deadbeef", last_rv1, 32'hDEADBEEF);
        cycle("wr_x5b", 1'b0, 1'b1, 5'd5, 32'h1, 5'd0, 5'd0);
        cycle("rd_x5b", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        check("x5_one", last_rv1, 32'h1);

        // x0 hardwiring, same cycle and next cycle.
        cycle("x0_wr", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        check("x0_same_cycle", last_rv1, 32'h0);
        cycle("x0_rd", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Bypass: old value 0x11, same-cycle write of 0x22.
        cycle("wr_x7", 1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
        cycle("byp_x7", 1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
        check("byp_rv1", last_rv1, 32'h22);
        cycle("after_byp", 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        check("after_byp_rv1", last_rv1, 32'h22);

        // Reset in READY with a concurrent write, then reset again at index 17.
        cycle("wr_x10", 1'b0, 1'b1, 5'd10, 32'h1234, 5'd0, 5'd0);
        cycle("rd_x10", 1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
        cycle("rst_ready", 1'b1, 1'b1, 5'd12, 32'h9999, 5'd10, 5'd0);
        for (int i = 0; i < 17; i++)
            cycle("partial_clear", 1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd0);
        cycle("rst_mid", 1'b1, 1'b0, 5'd0, 32'h0, 5'd10, 5'd0);
        wait_clear("reclear", 1'b0);
        cycle("x10_after", 1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd12);
        check("x10_cleared", last_rv1, 32'h0);
        check("x12_dropped", last_rv2, 32'h0);

        // Execute-stage integration: add and sub results written back.
        cycle("wr_x1", 1'b0, 1'b1, 5'd1, 32'd7, 5'd0, 5'd0);
        cycle("wr_x2", 1'b0, 1'b1, 5'd2, 32'd5, 5'd0, 5'd0);
        cycle("rd_ops", 1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        cycle("wb_add", 1'b0, 1'b1, 5'd3, last_rv1 + last_rv2, 5'd1, 5'd2);
        cycle("wb_sub", 1'b0, 1'b1, 5'd4, last_rv1 - last_rv2, 5'd3, 5'd0);
        cycle("rd_res", 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        check("add_x3", last_rv1, 32'd12);
        check("sub_x4", last_rv2, 32'd2);

        // Random traffic against the model.
        for (int i = 0; i < 200; i++)
            cycle("rand", 1'b0, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom,
                  5'($urandom_range(31)), 5'($urandom_range(31)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
